// File: rtl/pipe_control_unit_pkg.sv
// Shared types for the decode-to-execute control slice: opcode classes, the
// registered control bundle, its field enums and small decode lookups.
package pipe_control_unit_pkg;

  localparam int CNT_W = $clog2(64) + 1;

  typedef enum logic [5:0] {
    OP_INVALID,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_CSRRS, OP_FENCE, OP_ECALL
  } opcodeType_e;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
  } aluCtrl_e;

  typedef enum logic [1:0] {SRC1_NONE, SRC1_RS1, SRC1_PC} aluSrc1_e;
  typedef enum logic [1:0] {SRC2_NONE, SRC2_RS2, SRC2_IMM} aluSrc2_e;

  typedef enum logic [2:0] {
    BRANCH_NONE, BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT, BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU
  } branchCtrl_e;

  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsuCtrl_e;

  typedef enum logic [2:0] {
    RESULT_SRC_NONE, RESULT_SRC_ALU, RESULT_SRC_MEM, RESULT_SRC_PC_PLUS_4,
    RESULT_SRC_CSR, RESULT_SRC_MD
  } resultSrc_e;

  typedef enum logic [3:0] {
    MD_NONE, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } mdOp_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FULL} pcuState_e;

  typedef struct packed {
    logic        reg_wr_en;
    logic        mem_wr_en;
    logic        jump;
    logic        branch;
    branchCtrl_e branch_ctrl;
    aluCtrl_e    alu_ctrl;
    aluSrc1_e    alu_src1;
    aluSrc2_e    alu_src2;
    lsuCtrl_e    lsu_ctrl;
    resultSrc_e  result_src;
    mdOp_e       md_op;
    logic        illegal;
    logic        instret_inc;
  } ctrlBundle_t;

  localparam ctrlBundle_t CTRL_DEFAULT = '0;

  // Register and immediate forms of the same operation share one ALU op.
  function automatic aluCtrl_e alu_of(opcodeType_e op);
    case (op)
      OP_ADDI, OP_ADD:  return ALU_ADD;
      OP_SUB:           return ALU_SUB;
      OP_SLLI, OP_SLL:  return ALU_SLL;
      OP_SLTI, OP_SLT:  return ALU_SLT;
      OP_SLTIU, OP_SLTU: return ALU_SLTU;
      OP_XORI, OP_XOR:  return ALU_XOR;
      OP_SRLI, OP_SRL:  return ALU_SRL;
      OP_SRAI, OP_SRA:  return ALU_SRA;
      OP_ORI, OP_OR:    return ALU_OR;
      OP_ANDI, OP_AND:  return ALU_AND;
      default:          return ALU_NOP;
    endcase
  endfunction

  function automatic branchCtrl_e branch_of(opcodeType_e op);
    case (op)
      OP_BEQ:  return BRANCH_BEQ;
      OP_BNE:  return BRANCH_BNE;
      OP_BLT:  return BRANCH_BLT;
      OP_BGE:  return BRANCH_BGE;
      OP_BLTU: return BRANCH_BLTU;
      OP_BGEU: return BRANCH_BGEU;
      default: return BRANCH_NONE;
    endcase
  endfunction

  function automatic lsuCtrl_e lsu_of(opcodeType_e op);
    case (op)
      OP_LB:   return LSU_LB;
      OP_LH:   return LSU_LH;
      OP_LW:   return LSU_LW;
      OP_LBU:  return LSU_LBU;
      OP_LHU:  return LSU_LHU;
      OP_SB:   return LSU_SB;
      OP_SH:   return LSU_SH;
      OP_SW:   return LSU_SW;
      default: return LSU_NONE;
    endcase
  endfunction

  function automatic mdOp_e md_of(opcodeType_e op);
    case (op)
      OP_MUL:    return MD_MUL;
      OP_MULH:   return MD_MULH;
      OP_MULHSU: return MD_MULHSU;
      OP_MULHU:  return MD_MULHU;
      OP_DIV:    return MD_DIV;
      OP_DIVU:   return MD_DIVU;
      OP_REM:    return MD_REM;
      OP_REMU:   return MD_REMU;
      default:   return MD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pipe_control_unit_ctrl_decoder.sv
// Purely combinational decode of an opcode class into the control bundle and
// the number of cycles the op occupies before it may be handed to execute.
module ctrl_decoder import pipe_control_unit_pkg::*; #(
  parameter int M_EXT      = 0,
  parameter int ZICSR_EXT  = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  opcodeType_e      opcode_type,
  output ctrlBundle_t      ctrl,
  output logic [CNT_W-1:0] latency
);

  logic legal;

  always_comb begin
    ctrl    = CTRL_DEFAULT;
    latency = CNT_W'(1);
    legal   = 1'b1;
    case (opcode_type)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.alu_ctrl   = alu_of(opcode_type);
        ctrl.alu_src1   = SRC1_RS1;
        ctrl.alu_src2   = SRC2_IMM;
        ctrl.result_src = RESULT_SRC_ALU;
      end
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.alu_ctrl   = alu_of(opcode_type);
        ctrl.alu_src1   = SRC1_RS1;
        ctrl.alu_src2   = SRC2_RS2;
        ctrl.result_src = RESULT_SRC_ALU;
      end
      // LUI/AUIPC write rd from the ALU like any other arithmetic op.
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.alu_ctrl   = (opcode_type == OP_LUI) ? ALU_LUI : ALU_ADD;
        ctrl.alu_src1   = (opcode_type == OP_LUI) ? SRC1_NONE : SRC1_PC;
        ctrl.alu_src2   = SRC2_IMM;
        ctrl.result_src = RESULT_SRC_ALU;
      end
      OP_JAL, OP_JALR: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.alu_src1   = (opcode_type == OP_JAL) ? SRC1_PC : SRC1_RS1;
        ctrl.alu_src2   = SRC2_IMM;
        ctrl.result_src = RESULT_SRC_PC_PLUS_4;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        ctrl.branch      = 1'b1;
        ctrl.branch_ctrl = branch_of(opcode_type);
        ctrl.alu_ctrl    = ALU_ADD;
        ctrl.alu_src1    = SRC1_PC;
        ctrl.alu_src2    = SRC2_IMM;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.alu_src1   = SRC1_RS1;
        ctrl.alu_src2   = SRC2_IMM;
        ctrl.lsu_ctrl   = lsu_of(opcode_type);
        ctrl.result_src = RESULT_SRC_MEM;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.mem_wr_en = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src1  = SRC1_RS1;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.lsu_ctrl  = lsu_of(opcode_type);
      end
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (M_EXT != 0) begin
          ctrl.reg_wr_en  = 1'b1;
          ctrl.md_op      = md_of(opcode_type);
          ctrl.result_src = RESULT_SRC_MD;
          latency = (opcode_type inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
                    ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
        end else begin
          legal = 1'b0;
        end
      end
      OP_CSRRS: begin
        if (ZICSR_EXT != 0) begin
          ctrl.reg_wr_en  = 1'b1;
          ctrl.result_src = RESULT_SRC_CSR;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl         = CTRL_DEFAULT;
      ctrl.illegal = 1'b1;
      latency      = CNT_W'(1);
    end else begin
      ctrl.instret_inc = (ZICSR_EXT != 0);
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// One-entry register slice between decode and execute that also models the
// occupancy of multi-cycle MUL/DIV ops before the bundle is offered downstream.
module pipe_control_unit import pipe_control_unit_pkg::*; #(
  parameter int M_EXT      = 0,
  parameter int ZICSR_EXT  = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  opcodeType_e opcode_type,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output ctrlBundle_t ctrl,
  output logic        busy,
  output pcuState_e   state_dbg
);

  // valid/ready: a transfer happens on a rising clk edge where valid and ready
  // are both high; out_valid is a pure function of state, never of out_ready.
  pcuState_e        state, state_nxt, load_state;
  logic [CNT_W-1:0] cnt, dec_latency;
  ctrlBundle_t      dec_ctrl;
  logic             accept;

  ctrl_decoder #(
    .M_EXT(M_EXT), .ZICSR_EXT(ZICSR_EXT), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) u_decoder (
    .opcode_type (opcode_type),
    .ctrl        (dec_ctrl),
    .latency     (dec_latency)
  );

  assign accept     = in_valid && in_ready;
  assign load_state = (dec_latency > CNT_W'(1)) ? ST_WAIT : ST_FULL;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = load_state;
        ST_WAIT:  if (cnt <= CNT_W'(1)) state_nxt = ST_FULL;
        ST_FULL:  if (out_ready) state_nxt = accept ? load_state : ST_EMPTY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // rst_n gates in_ready so nothing is taken while the slice is held in reset.
  always_comb begin
    out_valid = (state == ST_FULL);
    busy      = (state == ST_WAIT);
    in_ready  = rst_n && !flush &&
                ((state == ST_EMPTY) || ((state == ST_FULL) && out_ready));
  end

  // cnt counts the remaining WAIT cycles; it reaches 0 as the entry turns FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ctrl <= CTRL_DEFAULT;
    end else if (flush) begin
      cnt  <= '0;
      ctrl <= CTRL_DEFAULT;
    end else if (accept) begin
      ctrl <= dec_ctrl;
      cnt  <= (dec_latency > CNT_W'(1)) ? dec_latency - CNT_W'(1) : '0;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios plus random traffic, checked
// by a queue-based scoreboard fed from a reference decode/timing model.
module tb_pipe_control_unit;
  import pipe_control_unit_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (M extension on)
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  opcodeType_e opcode_type;
  ctrlBundle_t ctrl;
  pcuState_e   state_dbg;

  // second DUT (M extension off), consumer always ready
  logic        m0_in_valid, m0_in_ready, m0_out_valid, m0_busy;
  opcodeType_e m0_op;
  ctrlBundle_t m0_ctrl;
  pcuState_e   m0_state;

  pipe_control_unit #(
    .M_EXT(1), .ZICSR_EXT(1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_type(opcode_type), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ctrl(ctrl), .busy(busy), .state_dbg(state_dbg)
  );

  pipe_control_unit #(.M_EXT(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
    .opcode_type(m0_op), .flush(1'b0), .out_valid(m0_out_valid),
    .out_ready(1'b1), .ctrl(m0_ctrl), .busy(m0_busy), .state_dbg(m0_state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference decode: what each instruction class must produce, and how many
  // cycles it takes from accept to being offered to execute.
  function automatic void ref_decode(input opcodeType_e op, input bit m_ext,
                                     output ctrlBundle_t c, output int lat);
    c   = '0;
    lat = 1;
    if (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
                   OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND}) begin
      case (op)
        OP_ADDI, OP_ADD:   c.alu_ctrl = ALU_ADD;
        OP_SUB:            c.alu_ctrl = ALU_SUB;
        OP_SLTI, OP_SLT:   c.alu_ctrl = ALU_SLT;
        OP_SLTIU, OP_SLTU: c.alu_ctrl = ALU_SLTU;
        OP_XORI, OP_XOR:   c.alu_ctrl = ALU_XOR;
        OP_ORI, OP_OR:     c.alu_ctrl = ALU_OR;
        OP_ANDI, OP_AND:   c.alu_ctrl = ALU_AND;
        OP_SLLI, OP_SLL:   c.alu_ctrl = ALU_SLL;
        OP_SRLI, OP_SRL:   c.alu_ctrl = ALU_SRL;
        default:           c.alu_ctrl = ALU_SRA;
      endcase
      c.reg_wr_en  = 1'b1;
      c.alu_src1   = SRC1_RS1;
      c.alu_src2   = (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                                 OP_SLLI, OP_SRLI, OP_SRAI}) ? SRC2_IMM : SRC2_RS2;
      c.result_src = RESULT_SRC_ALU;
    end else if (op == OP_LUI || op == OP_AUIPC) begin
      c.reg_wr_en  = 1'b1;
      c.alu_ctrl   = (op == OP_LUI) ? ALU_LUI : ALU_ADD;
      c.alu_src1   = (op == OP_LUI) ? SRC1_NONE : SRC1_PC;
      c.alu_src2   = SRC2_IMM;
      c.result_src = RESULT_SRC_ALU;
    end else if (op == OP_JAL || op == OP_JALR) begin
      c.reg_wr_en  = 1'b1;
      c.jump       = 1'b1;
      c.alu_ctrl   = ALU_ADD;
      c.alu_src1   = (op == OP_JAL) ? SRC1_PC : SRC1_RS1;
      c.alu_src2   = SRC2_IMM;
      c.result_src = RESULT_SRC_PC_PLUS_4;
    end else if (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
      c.branch      = 1'b1;
      c.branch_ctrl = branchCtrl_e'(int'(op) - int'(OP_BEQ) + int'(BRANCH_BEQ));
      c.alu_ctrl    = ALU_ADD;
      c.alu_src1    = SRC1_PC;
      c.alu_src2    = SRC2_IMM;
    end else if (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW}) begin
      c.lsu_ctrl   = lsuCtrl_e'(int'(op) - int'(OP_LB) + int'(LSU_LB));
      c.alu_ctrl   = ALU_ADD;
      c.alu_src1   = SRC1_RS1;
      c.alu_src2   = SRC2_IMM;
      c.mem_wr_en  = (op inside {OP_SB, OP_SH, OP_SW});
      c.reg_wr_en  = !c.mem_wr_en;
      c.result_src = c.mem_wr_en ? RESULT_SRC_NONE : RESULT_SRC_MEM;
    end else if (m_ext && (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                      OP_DIV, OP_DIVU, OP_REM, OP_REMU})) begin
      c.reg_wr_en  = 1'b1;
      c.md_op      = mdOp_e'(int'(op) - int'(OP_MUL) + int'(MD_MUL));
      c.result_src = RESULT_SRC_MD;
      lat          = (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) ? MUL_LAT : DIV_LAT;
    end else if (op == OP_CSRRS) begin
      c.reg_wr_en  = 1'b1;
      c.result_src = RESULT_SRC_CSR;
    end else begin
      c.illegal = 1'b1;
    end
    c.instret_inc = !c.illegal;
  endfunction

  // scoreboard: each accepted op is queued with the cycle it must first appear
  typedef struct packed {
    logic [31:0] rdy;
    ctrlBundle_t c;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    bit          exp_valid, exp_busy, exp_ready;
    ctrlBundle_t c;
    int          lat;
    if (rst_n) begin
      exp_valid = (exp_q.size() > 0) && (int'(exp_q[0].rdy) <= cyc);
      exp_busy  = (exp_q.size() > 0) && (int'(exp_q[0].rdy) > cyc);
      exp_ready = !flush && ((exp_q.size() == 0) || (exp_valid && out_ready));
      check("out_valid", out_valid, exp_valid);
      check("busy", busy, exp_busy);
      check("in_ready", in_ready, exp_ready);
      if (exp_valid && out_ready && out_valid) check("ctrl", ctrl, exp_q[0].c);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_valid && out_ready) void'(exp_q.pop_front());
        if (exp_ready && in_valid) begin
          ref_decode(opcode_type, 1'b1, c, lat);
          exp_q.push_back('{rdy: 32'(cyc + lat), c: c});
        end
      end
    end
  end

  // driver helpers: inputs change 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_seq_back_to_back();
    ctrlBundle_t c;
    int          lat;
    opcodeType_e ops[3];
    ops[0] = OP_ADDI; ops[1] = OP_SW; ops[2] = OP_BEQ;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode_type = ops[i];
      step();
      ref_decode(ops[i], 1'b1, c, lat);
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_ctrl", ctrl, c);
    end
    in_valid = 1'b0;
    step();
    check("b2b_drained", out_valid, 1'b0);
  endtask

  task automatic drive_div_latency();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    opcode_type = OP_DIV;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < DIV_LAT; i++) begin
      check("div_busy", busy, 1'b1);
      check("div_in_ready", in_ready, 1'b0);
      check("div_no_valid", out_valid, 1'b0);
      step();
    end
    check("div_valid_at_33", out_valid, 1'b1);
    check("div_busy_done", busy, 1'b0);
    check("div_md_op", ctrl.md_op, MD_DIV);
    step();
  endtask

  task automatic drive_backpressure();
    ctrlBundle_t c;
    int          lat;
    ref_decode(OP_ADD, 1'b1, c, lat);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    opcode_type = OP_ADD;
    step();
    opcode_type = OP_SUB;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_ctrl_stable", ctrl, c);
      check("bp_in_ready", in_ready, 1'b0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_one_transfer", out_valid, 1'b0);
  endtask

  task automatic drive_flush_mid_div();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    opcode_type = OP_DIV;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("fl_busy_before", busy, 1'b1);
    flush       = 1'b1;
    in_valid    = 1'b1;
    opcode_type = OP_ADD;
    check("fl_in_ready_low", in_ready, 1'b0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_state_empty", state_dbg, ST_EMPTY);
    check("fl_no_valid", out_valid, 1'b0);
    check("fl_ctrl_cleared", ctrl, CTRL_DEFAULT);
    step();
    check("fl_in_ready_after", in_ready, 1'b1);
    repeat (DIV_LAT + 5) step();
  endtask

  task automatic drive_m0_illegal();
    ctrlBundle_t c;
    int          lat;
    opcodeType_e ops[3];
    ops[0] = OP_MUL; ops[1] = OP_DIVU; ops[2] = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      m0_in_valid = 1'b1;
      m0_op       = ops[i];
      step();
      m0_in_valid = 1'b0;
      ref_decode(ops[i], 1'b0, c, lat);
      check("m0_valid", m0_out_valid, 1'b1);
      check("m0_ctrl", m0_ctrl, c);
      check("m0_illegal", m0_ctrl.illegal, (ops[i] != OP_ADD));
      check("m0_reg_wr_en", m0_ctrl.reg_wr_en, (ops[i] == OP_ADD));
      check("m0_instret_inc", m0_ctrl.instret_inc, (ops[i] == OP_ADD));
      step();
    end
  endtask

  task automatic async_reset_pulse(input string tag);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_ctrl"}, ctrl, CTRL_DEFAULT);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    opcode_type = OP_INVALID;
    m0_in_valid = 1'b0;
    m0_op       = OP_INVALID;
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ctrl", ctrl, CTRL_DEFAULT);
    check("rst_state", state_dbg, ST_EMPTY);
    step();
    rst_n = 1'b1;
    step();

    drive_seq_back_to_back();
    drive_div_latency();
    drive_backpressure();
    drive_flush_mid_div();
    drive_m0_illegal();

    // reset while an entry sits in FULL
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    opcode_type = OP_LW;
    step();
    in_valid = 1'b0;
    check("rfull_valid_before", out_valid, 1'b1);
    async_reset_pulse("rfull");
    step();

    // reset during a DIV wait; no pulse may follow
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    opcode_type = OP_REM;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    async_reset_pulse("rwait");
    repeat (DIV_LAT + 5) step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      opcodeType_e op;
      op = opcodeType_e'($urandom_range(0, 52));
      if ((op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && ($urandom_range(0, 3) != 0))
        op = OP_XORI;
      in_valid    = ($urandom_range(0, 2) != 0);
      opcode_type = op;
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 60) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
